standard_interpolator: RTL and testbench

- Upsampler: the counterpart of the standard decimator in the signal chain.
- Takes one multi-channel axi_stream sample, tagged by dest, and emits interpolation_ratio output beats for it on the same dest.
- Three modes: zero-insertion, sample-and-hold, or linear interpolation from that channel's previous sample.
- Sits between control/DSP cores and DAC/PWM-rate consumers that run at a higher sample rate.

---
 rtl/standard_interpolator.sv | 153 +++++++++++++++
 tb/tb_standard_interpolator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/standard_interpolator.sv
// Upsampler: each accepted sample becomes R output beats on its dest (zero-insert, hold or linear ramp).
// First beat one cycle after acceptance; input stalls for the whole burst, output holds data/dest while not ready.
module standard_interpolator #(
  parameter int MAX_INTERPOLATION_RATIO = 16,
  parameter int MAX_CHANNELS            = 6,
  parameter int DATA_WIDTH              = 16,
  parameter int MODE                    = 2,
  parameter int DEST_WIDTH              = 3,
  localparam int RW                     = $clog2(MAX_INTERPOLATION_RATIO) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic [DATA_WIDTH-1:0] data_in_data,
  input  logic [DEST_WIDTH-1:0] data_in_dest,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [DATA_WIDTH-1:0] data_out_data,
  output logic [DEST_WIDTH-1:0] data_out_dest,
  input  logic [RW-1:0]         interpolation_ratio
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, state_nxt;
  logic   armed;

  logic signed [DATA_WIDTH-1:0] sample_q;
  logic [DEST_WIDTH-1:0]        dest_q;
  logic [RW-1:0]                ratio_q;
  logic [RW-1:0]                beat_q;
  logic signed [DATA_WIDTH:0]   step_q;
  logic signed [DATA_WIDTH:0]   acc_q;
  logic [DATA_WIDTH-1:0]        out_q;
  logic signed [DATA_WIDTH-1:0] prev_mem [MAX_CHANNELS];

  logic [RW-1:0]                ratio_eff;
  logic [RW-1:0]                shamt;
  logic                         dest_ok;
  logic signed [DATA_WIDTH-1:0] prev_rd;
  logic signed [DATA_WIDTH:0]   sample_ext;
  logic signed [DATA_WIDTH:0]   prev_ext;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH:0]   step_nxt;
  logic signed [DATA_WIDTH:0]   first_nxt;
  logic signed [DATA_WIDTH:0]   acc_nxt;
  logic [DATA_WIDTH-1:0]        beat0;
  logic [DATA_WIDTH-1:0]        beat_next;
  logic                         last_beat;
  logic                         next_is_last;
  logic                         accept;

  function automatic logic [RW-1:0] floor_log2(input logic [RW-1:0] v);
    floor_log2 = '0;
    for (int i = 0; i < RW; i++)
      if (v[i]) floor_log2 = RW'(i);
  endfunction

  always_comb begin
    ratio_eff = RW'(1);
    if (interpolation_ratio > RW'(MAX_INTERPOLATION_RATIO))
      ratio_eff = RW'(MAX_INTERPOLATION_RATIO);
    else if (interpolation_ratio > RW'(1))
      ratio_eff = interpolation_ratio;
  end

  // Slope is computed one bit wider so full-scale swings cannot wrap.
  assign dest_ok    = {1'b0, data_in_dest} < (DEST_WIDTH+1)'(MAX_CHANNELS);
  assign prev_rd    = dest_ok ? prev_mem[data_in_dest] : '0;
  assign sample_ext = {data_in_data[DATA_WIDTH-1], data_in_data};
  assign prev_ext   = {prev_rd[DATA_WIDTH-1], prev_rd};
  assign diff       = sample_ext - prev_ext;
  assign shamt      = floor_log2(ratio_eff);
  assign step_nxt   = diff >>> shamt;
  assign first_nxt  = prev_ext + step_nxt;
  assign acc_nxt    = acc_q + step_q;

  assign last_beat    = (beat_q == ratio_q - RW'(1));
  assign next_is_last = (beat_q + RW'(2) == ratio_q);
  assign accept       = data_in_valid && data_in_ready && dest_ok;

  always_comb begin
    beat0 = data_in_data;
    if (MODE == 2 && ratio_eff != RW'(1))
      beat0 = first_nxt[DATA_WIDTH-1:0];
    beat_next = sample_q;
    if (MODE == 0)
      beat_next = '0;
    else if (MODE == 2 && !next_is_last)
      beat_next = acc_nxt[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    case (state)
      IDLE: begin
        data_in_ready = armed;
        if (accept) state_nxt = EMIT;
      end
      EMIT: begin
        data_out_valid = 1'b1;
        if (data_out_ready && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed    <= 1'b0;
      sample_q <= '0;
      dest_q   <= '0;
      ratio_q  <= RW'(1);
      beat_q   <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      for (int i = 0; i < MAX_CHANNELS; i++) prev_mem[i] <= '0;
    end else begin
      armed <= 1'b1;
      if (state == IDLE && accept) begin
        sample_q <= data_in_data;
        dest_q   <= data_in_dest;
        ratio_q  <= ratio_eff;
        beat_q   <= '0;
        step_q   <= step_nxt;
        acc_q    <= first_nxt;
        out_q    <= beat0;
      end
      if (state == EMIT && data_out_ready) begin
        if (last_beat) begin
          prev_mem[dest_q] <= sample_q;
        end else begin
          beat_q <= beat_q + RW'(1);
          acc_q  <= acc_nxt;
          out_q  <= beat_next;
        end
      end
    end
  end

  assign data_out_data = out_q;
  assign data_out_dest = dest_q;

endmodule

// File: tb/tb_standard_interpolator.sv
// Drives three interpolators (zero, hold, linear) from one stimulus stream and checks each
// against a per-sample burst model, plus literal beat lists for hand-worked cases.
module tb_standard_interpolator;

  localparam int NCH  = 6;
  localparam int MAXR = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        din_valid = 1'b0;
  logic [15:0] din_data  = '0;
  logic [2:0]  din_dest  = '0;
  logic [4:0]  ratio     = '0;
  logic        dout_ready = 1'b1;
  logic        rand_rdy  = 1'b0;

  logic [2:0]       rdy, vld;
  logic [2:0][15:0] dat;
  logic [2:0][2:0]  dst;

  standard_interpolator #(.MODE(0)) u_zero (
    .clock(clock), .reset(reset),
    .data_in_valid(din_valid), .data_in_ready(rdy[0]), .data_in_data(din_data), .data_in_dest(din_dest),
    .data_out_valid(vld[0]), .data_out_ready(dout_ready), .data_out_data(dat[0]), .data_out_dest(dst[0]),
    .interpolation_ratio(ratio));
  standard_interpolator #(.MODE(1)) u_hold (
    .clock(clock), .reset(reset),
    .data_in_valid(din_valid), .data_in_ready(rdy[1]), .data_in_data(din_data), .data_in_dest(din_dest),
    .data_out_valid(vld[1]), .data_out_ready(dout_ready), .data_out_data(dat[1]), .data_out_dest(dst[1]),
    .interpolation_ratio(ratio));
  standard_interpolator #(.MODE(2)) u_lin (
    .clock(clock), .reset(reset),
    .data_in_valid(din_valid), .data_in_ready(rdy[2]), .data_in_data(din_data), .data_in_dest(din_dest),
    .data_out_valid(vld[2]), .data_out_ready(dout_ready), .data_out_data(dat[2]), .data_out_dest(dst[2]),
    .interpolation_ratio(ratio));

  int n_cmp = 0;
  int n_bad = 0;

  int          prev_m [NCH];
  logic [18:0] expq [3][$];
  logic [18:0] got  [3][$];
  logic        armed_m = 1'b0;
  logic [2:0]  stall_prev = '0;
  logic [18:0] held [3];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected beats straight from the mode rules, as a closed-form ramp per beat index.
  task automatic model_accept(input logic [15:0] d, input logic [2:0] ds, input logic [4:0] r);
    int R, sh, s, p, diff, step, v;
    if (int'(ds) >= NCH) return;
    R  = (r <= 1) ? 1 : ((r > MAXR) ? MAXR : int'(r));
    sh = 0;
    while ((1 << (sh + 1)) <= R) sh++;
    s    = $signed(d);
    p    = prev_m[ds];
    diff = s - p;
    step = diff >>> sh;
    for (int k = 0; k < R; k++) begin
      expq[0].push_back({ds, (k == 0) ? d : 16'h0000});
      expq[1].push_back({ds, d});
      v = (k == R - 1) ? s : p + (k + 1) * step;
      expq[2].push_back({ds, 16'(v)});
    end
    prev_m[ds] = s;
  endtask

  always @(posedge clock or negedge reset)
    if (!reset) armed_m <= 1'b0;
    else        armed_m <= 1'b1;

  always @(negedge reset) begin
    for (int i = 0; i < 3; i++) expq[i].delete();
    for (int c = 0; c < NCH; c++) prev_m[c] = 0;
  end

  always @(posedge clock)
    if (rand_rdy) begin
      #1 dout_ready = ($urandom_range(0, 3) != 0);
    end

  always @(negedge clock) begin
    logic [18:0] e;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        chk("reset_valid", int'(vld[i]), 0);
        chk("reset_ready", int'(rdy[i]), 0);
        chk("reset_data",  int'(dat[i]), 0);
        chk("reset_dest",  int'(dst[i]), 0);
      end
      stall_prev = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk("in_ready", int'(rdy[i]), int'(armed_m && expq[i].size() == 0));
        chk("out_valid", int'(vld[i]), int'(expq[i].size() != 0));
        if (stall_prev[i]) chk("stall_stable", int'({dst[i], dat[i]}), int'(held[i]));
        if (vld[i] && dout_ready) begin
          if (expq[i].size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = expq[i].pop_front();
            chk("beat_data", int'(dat[i]), int'(e[15:0]));
            chk("beat_dest", int'(dst[i]), int'(e[18:16]));
          end
          got[i].push_back({dst[i], dat[i]});
        end
        stall_prev[i] = vld[i] && !dout_ready;
        held[i] = {dst[i], dat[i]};
      end
      if (din_valid && rdy[2]) model_accept(din_data, din_dest, ratio);
    end
  end

  task automatic clear_got();
    for (int i = 0; i < 3; i++) got[i].delete();
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clock);
    while (!rdy[2] && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) chk("accept_timeout", 1, 0);
    @(posedge clock); #1;
    din_valid = 1'b0;
    ratio = 5'($urandom_range(0, 31));
  endtask

  task automatic send(input logic [15:0] d, input logic [2:0] ds, input logic [4:0] r);
    @(posedge clock); #1;
    din_valid = 1'b1; din_data = d; din_dest = ds; ratio = r;
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(expq[2].size() == 0 && vld[2] == 1'b0) && n < 500);
    if (n >= 500) chk("drain_timeout", 1, 0);
  endtask

  task automatic expect4(input string nm, input int i, input int n,
                         input int a, input int b, input int c, input int d, input int ds);
    int v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    chk({nm, "_count"}, got[i].size(), n);
    for (int k = 0; k < n && k < 4 && k < got[i].size(); k++) begin
      chk(nm, int'($signed(got[i][k][15:0])), v[k]);
      chk({nm, "_dest"}, int'(got[i][k][18:16]), ds);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    clear_got(); send(-16'sd10, 3'd3, 5'd4); wait_idle();
    expect4("lin_neg10", 2, 4, -3, -6, -9, -10, 3);
    clear_got(); send(16'd4, 3'd3, 5'd4); wait_idle();
    expect4("lin_then4", 2, 4, -7, -4, -1, 4, 3);

    clear_got(); send(16'h8000, 3'd0, 5'd4); wait_idle();
    expect4("hold_8000", 1, 4, -32768, -32768, -32768, -32768, 0);
    expect4("zero_8000", 0, 4, -32768, 0, 0, 0, 0);
    expect4("lin_8000", 2, 4, -8192, -16384, -24576, -32768, 0);
    clear_got(); send(16'h7fff, 3'd0, 5'd4); wait_idle();
    expect4("lin_fullswing", 2, 4, -16385, -2, 16381, 32767, 0);
    expect4("zero_7fff", 0, 4, 32767, 0, 0, 0, 0);
    expect4("hold_7fff", 1, 4, 32767, 32767, 32767, 32767, 0);

    clear_got(); send(16'd1234, 3'd1, 5'd0); wait_idle();
    for (int i = 0; i < 3; i++) expect4("ratio0", i, 1, 1234, 0, 0, 0, 1);
    clear_got(); send(-16'sd5, 3'd1, 5'd1); wait_idle();
    for (int i = 0; i < 3; i++) expect4("ratio1", i, 1, -5, 0, 0, 0, 1);
    clear_got(); send(16'd100, 3'd4, 5'd31); wait_idle();
    for (int i = 0; i < 3; i++) chk("ratio31_count", got[i].size(), 16);
    clear_got(); send(16'd55, 3'd7, 5'd4); wait_idle();
    chk("dest7_count", got[2].size(), 0);

    send(16'd100, 3'd2, 5'd1); send(-16'sd300, 3'd3, 5'd4); wait_idle();
    clear_got(); send(16'd200, 3'd2, 5'd2); wait_idle();
    expect4("ch2_history", 2, 2, 150, 200, 0, 0, 2);

    clear_got(); send(16'h8000, 3'd5, 5'd4);
    din_valid = 1'b1; din_data = 16'd77; din_dest = 3'd5; ratio = 5'd2;
    begin
      logic [6:0] pat;
      pat = 7'b1001011;
      for (int k = 6; k >= 0; k--) begin
        dout_ready = pat[k];
        @(posedge clock); #1;
      end
    end
    expect4("bp_hold", 1, 4, -32768, -32768, -32768, -32768, 5);
    dout_ready = 1'b1;
    wait_accept(); wait_idle();

    clear_got(); send(16'd1000, 3'd1, 5'd4);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("midburst_valid", int'(vld[i]), 0);
    chk("midburst_beats", got[1].size(), 1);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    clear_got(); send(16'd8, 3'd0, 5'd4); wait_idle();
    expect4("lin_after_reset", 2, 4, 2, 4, 6, 8, 0);

    rand_rdy = 1'b1;
    for (int t = 0; t < 200; t++)
      send(16'($urandom), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    wait_idle();
    rand_rdy = 1'b0;
    #2 dout_ready = 1'b1;
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
